// File: rtl/alu_sequencer_pkg.sv
// ============================================================================
// Module   : alu_seq_pkg
// Brief    : Opcodes, FSM states, ALU select encodings and wait-count helper
//            shared by the ALU issue sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;
  localparam logic [2:0] OP_DIV = 3'd5;
  localparam logic [2:0] OP_LDA = 3'd6;
  localparam logic [2:0] OP_CLR = 3'd7;

  localparam logic [2:0] SEL_ADD = 3'd0;
  localparam logic [2:0] SEL_SUB = 3'd1;
  localparam logic [2:0] SEL_AND = 3'd2;
  localparam logic [2:0] SEL_OR  = 3'd3;
  localparam logic [2:0] SEL_MUL = 3'd4;
  localparam logic [2:0] SEL_DIV = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_e;

  function automatic logic [3:0] op_wait(input logic [2:0] op,
                                         input logic [3:0] mul_wait,
                                         input logic [3:0] div_wait);
    case (op)
      OP_MUL:  op_wait = mul_wait;
      OP_DIV:  op_wait = div_wait;
      default: op_wait = 4'd1;
    endcase
  endfunction

  function automatic logic [2:0] op_to_sel(input logic [2:0] op);
    case (op)
      OP_SUB:  op_to_sel = SEL_SUB;
      OP_AND:  op_to_sel = SEL_AND;
      OP_OR:   op_to_sel = SEL_OR;
      OP_MUL:  op_to_sel = SEL_MUL;
      OP_DIV:  op_to_sel = SEL_DIV;
      default: op_to_sel = SEL_ADD;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_sequencer_latency_counter.sv
// ============================================================================
// Module   : alu_latency_counter
// Brief    : 4-bit loadable down-counter that flags the final wait cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_latency_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       last
);

  logic [3:0] count_q;

  // Free-running decrement that parks at zero, so no separate enable is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != 4'd0) begin
      count_q <= count_q - 4'd1;
    end
  end

  assign last = (count_q == 4'd1);

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// Module   : alu_sequencer
// Brief    : Multi-cycle issue controller holding ALU operands stable for a
//            per-op settle window and writing the result back to the acc.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned MUL_WAIT = 2,
  parameter int unsigned DIV_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_sub,
  output logic [2:0] alu_op_select,
  input  logic [7:0] alu_result,
  output logic [7:0] acc,
  output logic       done,
  output logic       err,
  output logic       busy
);

  localparam logic [3:0] C_MUL_WAIT = 4'(MUL_WAIT);
  localparam logic [3:0] C_DIV_WAIT = 4'(DIV_WAIT);

  state_e     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] b_q, b_d;
  logic [2:0] sel_q, sel_d;
  logic       sub_q, sub_d;
  logic       err_q, err_d;
  logic       w_cnt_load;
  logic [3:0] w_cnt_val;
  logic       w_cnt_last;
  logic       w_xfer;

  alu_latency_counter u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (w_cnt_load),
    .load_val (w_cnt_val),
    .last     (w_cnt_last)
  );

  assign cmd_ready     = (state_q == ST_IDLE) && !rst;
  assign w_xfer        = cmd_valid && cmd_ready;
  assign alu_a         = acc_q;
  assign alu_b         = b_q;
  assign alu_sub       = sub_q;
  assign alu_op_select = sel_q;
  assign acc           = acc_q;
  assign done          = (state_q == ST_WB);
  assign err           = (state_q == ST_WB) && err_q;
  assign busy          = (state_q != ST_IDLE);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    b_d        = b_q;
    sel_d      = sel_q;
    sub_d      = sub_q;
    err_d      = err_q;
    w_cnt_load = 1'b0;
    w_cnt_val  = 4'd0;
    case (state_q)
      ST_IDLE: begin
        if (w_xfer) begin
          err_d = 1'b0;
          case (cmd_op)
            OP_LDA: begin
              acc_d   = cmd_data;
              state_d = ST_WB;
            end
            OP_CLR: begin
              acc_d   = 8'd0;
              state_d = ST_WB;
            end
            default: begin
              b_d   = cmd_data;
              sel_d = op_to_sel(cmd_op);
              sub_d = (cmd_op == OP_SUB);
              // Divide-by-zero never touches the ALU; retire with the error flag.
              if (cmd_op == OP_DIV && cmd_data == 8'd0) begin
                err_d   = 1'b1;
                state_d = ST_WB;
              end else begin
                w_cnt_load = 1'b1;
                w_cnt_val  = op_wait(cmd_op, C_MUL_WAIT, C_DIV_WAIT);
                state_d    = ST_EXEC;
              end
            end
          endcase
        end
      end
      ST_EXEC: begin
        if (w_cnt_last) begin
          acc_d   = alu_result;
          state_d = ST_WB;
        end
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= 8'd0;
      b_q     <= 8'd0;
      sel_q   <= 3'd0;
      sub_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      sub_q   <= sub_d;
      err_q   <= err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// Module   : tb_alu_sequencer
// Brief    : Directed self-checking bench for alu_sequencer with an ALU model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_sub;
  logic [2:0] alu_op_select;
  logic [7:0] alu_result;
  logic [7:0] acc;
  logic       done;
  logic       err;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_sequencer #(.MUL_WAIT(2), .DIV_WAIT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_data      (cmd_data),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_sub       (alu_sub),
    .alu_op_select (alu_op_select),
    .alu_result    (alu_result),
    .acc           (acc),
    .done          (done),
    .err           (err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Combinational 8-bit ALU standing in for the parent's instance.
  always_comb begin
    logic [15:0] prod;
    prod = 16'(alu_a) * 16'(alu_b);
    case (alu_op_select)
      3'd0, 3'd1: alu_result = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);
      3'd2:       alu_result = alu_a & alu_b;
      3'd3:       alu_result = alu_a | alu_b;
      3'd4:       alu_result = prod[7:0];
      3'd5:       alu_result = (alu_b == 8'd0) ? 8'hFF : (alu_a / alu_b);
      default:    alu_result = 8'h00;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one command in an IDLE cycle; returns in cycle T+1.
  task automatic issue(input logic [2:0] op, input logic [7:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic load_acc(input logic [7:0] v);
    issue(3'd6, v);
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 8'd0;
    repeat (3) step();
    n_checks++; if (acc !== 8'h00) begin n_fail++; $display("FAIL reset_acc: got %h exp 00", acc); end
    n_checks++; if ({done, err, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b exp 000", {done, err, busy}); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b exp 0", cmd_ready); end
    n_checks++; if ({alu_b, alu_op_select, alu_sub} !== 12'h000) begin n_fail++; $display("FAIL reset_alu: got %h exp 000", {alu_b, alu_op_select, alu_sub}); end
    rst = 1'b0;
    #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b exp 1", cmd_ready); end
    step();
  endtask

  task automatic test_lda();
    issue(3'd6, 8'h05);
    n_checks++; if ({done, err, busy} !== 3'b101) begin n_fail++; $display("FAIL lda_done: got %b exp 101", {done, err, busy}); end
    n_checks++; if (acc !== 8'h05) begin n_fail++; $display("FAIL lda_acc: got %h exp 05", acc); end
    step();
    n_checks++; if ({done, busy, cmd_ready} !== 3'b001) begin n_fail++; $display("FAIL lda_idle: got %b exp 001", {done, busy, cmd_ready}); end
  endtask

  task automatic test_add_wrap();
    load_acc(8'hF0);
    issue(3'd0, 8'h20);
    n_checks++; if ({done, busy, cmd_ready} !== 3'b010) begin n_fail++; $display("FAIL add_exec_flags: got %b exp 010", {done, busy, cmd_ready}); end
    n_checks++; if ({alu_op_select, alu_sub, alu_b} !== {3'd0, 1'b0, 8'h20}) begin n_fail++; $display("FAIL add_exec_alu: got %h exp 020", {alu_op_select, alu_sub, alu_b}); end
    step();
    n_checks++; if ({done, err} !== 2'b10) begin n_fail++; $display("FAIL add_done: got %b exp 10", {done, err}); end
    n_checks++; if (acc !== 8'h10) begin n_fail++; $display("FAIL add_acc: got %h exp 10", acc); end
    step();
  endtask

  task automatic test_sub_mul();
    issue(3'd1, 8'h03);
    n_checks++; if ({alu_op_select, alu_sub} !== {3'd1, 1'b1}) begin n_fail++; $display("FAIL sub_alu: got %b exp 0011", {alu_op_select, alu_sub}); end
    step();
    n_checks++; if ({done, acc} !== {1'b1, 8'h0D}) begin n_fail++; $display("FAIL sub_result: got %h exp 10d", {done, acc}); end
    step();
    issue(3'd4, 8'h14);
    for (int i = 1; i <= 2; i++) begin
      n_checks++; if ({done, alu_op_select, alu_sub, alu_b, alu_a} !== {1'b0, 3'd4, 1'b0, 8'h14, 8'h0D}) begin
        n_fail++; $display("FAIL mul_exec_c%0d: got %h exp 08140d", i, {done, alu_op_select, alu_sub, alu_b, alu_a}); end
      if (i < 2) step();
    end
    step();
    n_checks++; if ({done, err, acc} !== {2'b10, 8'h04}) begin n_fail++; $display("FAIL mul_result: got %h exp 204", {done, err, acc}); end
    step();
  endtask

  task automatic test_div();
    load_acc(8'h64);
    issue(3'd5, 8'h07);
    for (int i = 1; i <= 4; i++) begin
      n_checks++; if ({done, busy, alu_op_select} !== {2'b01, 3'd5}) begin n_fail++; $display("FAIL div_exec_c%0d: got %b exp 01101", i, {done, busy, alu_op_select}); end
      step();
    end
    n_checks++; if ({done, err, acc} !== {2'b10, 8'h0E}) begin n_fail++; $display("FAIL div_result: got %h exp 20e", {done, err, acc}); end
    step();
    issue(3'd5, 8'h00);
    n_checks++; if ({done, err, acc} !== {2'b11, 8'h0E}) begin n_fail++; $display("FAIL div0_result: got %h exp 30e", {done, err, acc}); end
    step();
    n_checks++; if ({done, err, busy} !== 3'b000) begin n_fail++; $display("FAIL div0_after: got %b exp 000", {done, err, busy}); end
  endtask

  task automatic test_back_to_back();
    int dones = 0, ready_busy = 0, ready_cyc = 0;
    load_acc(8'h03);
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_data = 8'h02;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) dones++;
      if (cmd_ready && busy) ready_busy++;
      if (cmd_ready) ready_cyc++;
    end
    cmd_valid = 1'b0;
    repeat (3) begin
      step();
      if (done) dones++;
    end
    n_checks++; if (dones !== 2) begin n_fail++; $display("FAIL b2b_dones: got %0d exp 2", dones); end
    n_checks++; if (acc !== 8'h0C) begin n_fail++; $display("FAIL b2b_acc: got %h exp 0c", acc); end
    n_checks++; if (ready_busy !== 0) begin n_fail++; $display("FAIL b2b_ready_busy: got %0d exp 0", ready_busy); end
    n_checks++; if (ready_cyc !== 2) begin n_fail++; $display("FAIL b2b_ready_cycles: got %0d exp 2", ready_cyc); end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    load_acc(8'h64);
    issue(3'd5, 8'h07);
    step();
    rst = 1'b1;
    step();
    n_checks++; if ({acc, done, busy, cmd_ready} !== {8'h00, 3'b000}) begin n_fail++; $display("FAIL rstmid_state: got %h exp 000", {acc, done, busy, cmd_ready}); end
    rst = 1'b0;
    #1;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b exp 1", cmd_ready); end
    repeat (6) begin
      step();
      if (done) dones++;
    end
    n_checks++; if ({dones[3:0], acc} !== 12'h000) begin n_fail++; $display("FAIL rstmid_no_done: got %h exp 000", {dones[3:0], acc}); end
  endtask

  initial begin
    test_reset();
    test_lda();
    test_add_wrap();
    test_sub_mul();
    test_div();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle issue controller that drives the 8-bit ALU from the command side. It accepts one command per handshake and owns the accumulator and data operand registers. It presents them to the ALU's `a`/`b`/`sub`/`op_select` inputs and holds them stable for a per-operation settle window, since the gate-level multiplier and divider are multicycle paths. At the end of the window it writes the ALU result back into the accumulator. It sits between instruction decode and the combinational ALU.

## Interface
- `MUL_WAIT`, default 2: EXEC cycles for multiply. Legal range 1..15.
- `DIV_WAIT`, default 4: EXEC cycles for divide. Legal range 1..15.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_op`  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 MUL, 5 DIV, 6 LDA, 7 CLR.
- `cmd_data`  in  8  operand, loaded into the data register.
- `alu_a`  out  8  to ALU `a`; always equals `acc`.
- `alu_b`  out  8  to ALU `b`; registered data operand.
- `alu_sub`  out  1  to ALU `sub`.
- `alu_op_select`  out  3  to ALU `op_select`; only values 0..5 are ever driven.
- `alu_result`  in  8  from ALU `result`.
- `acc`  out  8  accumulator.
- `done`  out  1  one-cycle pulse when a command retires.
- `err`  out  1  qualified by `done`; set for divide-by-zero.
- `busy`  out  1  high whenever not in IDLE.

## Operation
- **States:** IDLE, EXEC, WB.
- **Handshake:** `cmd_ready` is high only in IDLE with `rst` low. A command transfers when `cmd_valid && cmd_ready`. `cmd_op`/`cmd_data` are sampled only on the transfer edge.
- **ALU ops (0..5), on transfer:**
  - `b_reg <= cmd_data`.
  - Op register latched.
  - `alu_op_select <= cmd_op`.
  - `alu_sub <= (cmd_op==1)`.
  - Wait counter loaded with N: 1 for ADD/SUB/AND/OR, `MUL_WAIT` for MUL, `DIV_WAIT` for DIV.
  - Next state EXEC.
- **EXEC:** counter decrements each cycle; `alu_*` outputs held constant. On the cycle the counter is 1: `acc <= alu_result`, next state WB.
- **WB:** `done=1`, `err=0`; next state IDLE.
- **DIV with `cmd_data==0`:** EXEC is skipped; `acc` is unchanged; next state WB with `err=1`.
- **LDA:** `acc <= cmd_data`, next state WB.
- **CLR:** `acc <= 0`, next state WB.
- **Widths:** the result is 8-bit and the controller applies no extension. MUL yields the low byte of the product; DIV yields the quotient. ADD/SUB wrap mod 256.
- **Outside WB:** `err` is 0. When not in EXEC, `alu_op_select` and `alu_sub` hold their last values.

## Timing
- **Reset values (any cycle `rst`=1):**
  - state IDLE.
  - `acc`, `b_reg`, `alu_b` = 0.
  - `alu_op_select` = 0, `alu_sub` = 0.
  - `done`, `err`, `busy` = 0.
  - Counter = 0.
  - `cmd_ready` = 0 while `rst` is high.
- **Reset mid-EXEC:** the command is discarded, `acc` clears, and no `done` is produced.
- **Latency from the transfer edge T:**
  - ALU op: `acc` is updated at edge T+N; `done` is high in cycle T+N+1.
  - LDA/CLR/div-by-zero: `done` is high in cycle T+1.
- **Throughput:**
  - `cmd_ready` returns high the cycle after `done`.
  - The next command can transfer at the earliest in the cycle after WB.
  - Minimum spacing between transfers: N+2 cycles for ALU ops, 2 cycles otherwise.
- **Busy/idle:** `cmd_valid` held during busy is ignored, not lost; the source keeps it asserted. `busy`=1 in EXEC and WB.

## Structure
- **Package `alu_seq_pkg`:**
  - Opcode constants `OP_ADD`..`OP_CLR`.
  - State enum (IDLE/EXEC/WB).
  - ALU `op_select` encodings 0..5.
  - Function `op_wait(op)` returning N.
- **Sub-module `alu_latency_counter`:** 4-bit loadable down-counter. Inputs `load`, `load_val`; output `last` (count==1). Reused later for memory wait states.
- The ALU is instantiated by the parent, not inside this block.

## Test plan
- **Reset then LDA:** reset, then LDA `0x05` -> `acc`=`0x05`, `done` at T+1, `err`=0.
- **ADD with wrap:** `acc`=`0xF0`, ADD `0x20` -> `acc`=`0x10` at T+1, `done` at T+2; `alu_sub`=0, `alu_op_select`=0 throughout EXEC.
- **SUB then MUL:** `acc`=`0x10`, SUB `0x03` -> `acc`=`0x0D`, `alu_sub`=1. Then MUL `0x14` with `MUL_WAIT`=2 -> `acc`=`0x04` (`0x104` truncated), `done` at T+3, inputs stable for 2 cycles.
- **DIV and divide-by-zero:** `acc`=`0x64`, DIV `0x07` with `DIV_WAIT`=4 -> `acc`=`0x0E`, `done` at T+5. Then DIV `0x00` -> `acc` unchanged, `done`+`err` at T+1.
- **Backpressure:** `cmd_valid` held high during a MUL -> exactly one transfer per retire, `cmd_ready`=0 while `busy`, no duplicated or dropped command.
- **Reset mid-operation:** assert `rst` in the 2nd EXEC cycle of a DIV -> `acc`=0, no `done`, IDLE next cycle; `cmd_ready` high once `rst` drops.
